// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider: default width and FSM state encoding.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned STATE_W       = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_LOAD_B = 2'd1;
  localparam logic [STATE_W-1:0] S_SUB    = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/div_ctrl.sv
// Controller FSM for the repeated-subtraction divider; busy/done decode straight from state.
module div_ctrl
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bz,
  input  logic lt,
  output logic ld_r,
  output logic clr_q,
  output logic ld_d,
  output logic sub_r,
  output logic inc_q,
  output logic set_z,
  output logic busy,
  output logic done
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_r      = 1'b0;
    clr_q     = 1'b0;
    ld_d      = 1'b0;
    sub_r     = 1'b0;
    inc_q     = 1'b0;
    set_z     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld_r      = 1'b1;
          clr_q     = 1'b1;
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        busy = 1'b1;
        ld_d = 1'b1;
        if (bz) begin
          set_z     = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        busy = 1'b1;
        if (lt) begin
          state_nxt = S_DONE;
        end else begin
          sub_r = 1'b1;
          inc_q = 1'b1;
        end
      end
      default: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction; dividend and divisor arrive on one shared bus.
module div_repsub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic             z_q;
  logic             ld_r, clr_q, ld_d, sub_r, inc_q, set_z;
  logic             bz, lt;

  assign bz = (data_in == '0);
  assign lt = (r_q < d_q);

  div_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bz    (bz),
    .lt    (lt),
    .ld_r  (ld_r),
    .clr_q (clr_q),
    .ld_d  (ld_d),
    .sub_r (sub_r),
    .inc_q (inc_q),
    .set_z (set_z),
    .busy  (busy),
    .done  (done)
  );

  // Subtract is only enabled when R >= D, so it cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
      z_q <= 1'b0;
    end else begin
      if (ld_r)       r_q <= data_in;
      else if (sub_r) r_q <= r_q - d_q;

      if (ld_d) d_q <= data_in;

      if (clr_q)      q_q <= '0;
      else if (set_z) q_q <= '1;
      else if (inc_q) q_q <= q_q + WIDTH'(1);

      if (clr_q)      z_q <= 1'b0;
      else if (set_z) z_q <= 1'b1;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = z_q;

endmodule

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: directed divisions, zero divisor, ignored starts, async reset.
module tb_div_repsub;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           e0;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   applied    = 0;
  int   miscompares = 0;
  int   issued     = 0;
  int   completed  = 0;

  div_repsub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", longint'(quotient), longint'(e.q));
        check("remainder", longint'(remainder), longint'(e.r));
        check("div_by_zero", longint'(div_by_zero), longint'(e.z));
        check("latency", longint'(cyc - e.e0), longint'(e.lat));
        check("busy_at_done", longint'(busy), 0);
        completed++;
      end
    end
  end

  // Starts in an IDLE cycle: dividend on edge 0, divisor in the following cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int lat);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    if (push) begin
      e.q = q; e.r = r; e.z = z; e.lat = lat; e.e0 = cyc + 1;
      sb.push_back(e);
      issued++;
    end
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
    check("busy_in_load_b", longint'(busy), 1);
    @(negedge clk);
    data_in = '0;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (completed == issued) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int lat);
    issue(a, b, 1'b1, q, r, z, lat);
    wait_done(lat + 10);
  endtask

  initial begin
    bit seen;
    int stray;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", longint'(quotient), 0);
    check("rst_remainder", longint'(remainder), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_dbz", longint'(div_by_zero), 0);
    rst = 1'b0;

    run(16'd100, 16'd7,   16'd14, 16'd2,  1'b0, 16);
    run(16'd7,   16'd100, 16'd0,  16'd7,  1'b0, 2);
    run(16'd0,   16'd5,   16'd0,  16'd0,  1'b0, 2);
    run(16'd50,  16'd0,   16'hFFFF, 16'd50, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("dbz_held_idle", longint'(div_by_zero), 1);
    check("q_held_idle", longint'(quotient), 65535);
    run(16'd9,   16'd3,   16'd3,  16'd0,  1'b0, 5);
    run(16'hFFFF, 16'd1,  16'hFFFF, 16'd0, 1'b0, 65537);

    // Starts during SUB and during DONE must be ignored.
    issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 16);
    repeat (3) @(negedge clk);
    start = 1'b1; data_in = 16'd3;
    @(negedge clk);
    start = 1'b0; data_in = '0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout_ignore", 0, 1);
    start = 1'b1; data_in = 16'd55;
    @(negedge clk);
    start = 1'b0; data_in = '0;
    check("ignored_start_idle", longint'(busy), 0);
    repeat (3) @(negedge clk);
    check("ignored_start_busy", longint'(busy), 0);
    check("ignored_start_q", longint'(quotient), 14);
    check("ignored_start_r", longint'(remainder), 2);

    // Asynchronous reset mid-SUB: outputs clear at once, no done follows.
    issue(16'd100, 16'd7, 1'b0, '0, '0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_quotient", longint'(quotient), 0);
    check("arst_remainder", longint'(remainder), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_dbz", longint'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("no_done_after_abort", longint'(stray), 0);
    run(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 5);

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
